// File: rtl/pipe_ctrl.sv
// Pipeline control for a 5-stage core: PC sequencing, hazard stalls, branch
// redirects and an ECALL trap path that drains the pipe before vectoring to mtvec.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        stall_flag,
  input  logic        ecall_flag,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] mtvec,
  output logic [31:0] pc,
  output logic        if_id_hold,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        mepc_we,
  output logic [31:0] mepc_data,
  output logic [31:0] mcause_data,
  output logic        trap_busy
);

  typedef enum logic [2:0] {BOOT, RUN, DRAIN, TRAP, REDIRECT} state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic [31:0] pc_next;
  logic [31:0] mepc, mepc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      cnt   <= '0;
      mepc  <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      cnt   <= cnt_next;
      mepc  <= mepc_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    cnt_next     = cnt;
    mepc_next    = mepc;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    mepc_we      = 1'b0;
    trap_busy    = 1'b0;
    unique case (state)
      BOOT: begin
        if_id_flush = 1'b1;
        state_next  = RUN;
      end
      RUN: begin
        if (br_taken) begin
          pc_next      = br_target;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (ecall_flag && id_valid) begin
          mepc_next    = id_pc;
          cnt_next     = DRAIN_LOAD;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
          state_next   = DRAIN;
        end else if (stall_flag && id_valid) begin
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
        end else begin
          pc_next = pc + 32'd4;
        end
      end
      DRAIN: begin
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
        trap_busy    = 1'b1;
        if (cnt == 3'd0) state_next = TRAP;
        else             cnt_next   = cnt - 3'd1;
      end
      TRAP: begin
        mepc_we      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
        trap_busy    = 1'b1;
        state_next   = REDIRECT;
      end
      REDIRECT: begin
        pc_next      = {mtvec[31:2], 2'b00};
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        trap_busy    = 1'b1;
        state_next   = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  assign mepc_data   = mepc;
  assign mcause_data = 32'd11;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle vector table plus a hand-written
// ECALL latency sequence.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        stall_flag;
  logic        ecall_flag;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] mtvec;
  logic [31:0] pc;
  logic        if_id_hold;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        mepc_we;
  logic [31:0] mepc_data;
  logic [31:0] mcause_data;
  logic        trap_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.RESET_PC(32'h0000_0000), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .stall_flag(stall_flag), .ecall_flag(ecall_flag), .br_taken(br_taken),
    .br_target(br_target), .mtvec(mtvec), .pc(pc), .if_id_hold(if_id_hold),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .mepc_we(mepc_we),
    .mepc_data(mepc_data), .mcause_data(mcause_data), .trap_busy(trap_busy)
  );

  typedef struct {
    logic        rst_n, valid;
    logic [31:0] idpc;
    logic        stall, ecall, br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_hold, e_flush, e_bub, e_we;
    logic [31:0] e_mepc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [31:0] ip,
                     input logic s, input logic e, input logic b, input logic [31:0] t,
                     input logic [31:0] xpc, input logic xh, input logic xf,
                     input logic xb, input logic xw, input logic [31:0] xm,
                     input logic xy);
    vec_t w;
    w.rst_n = r; w.valid = v; w.idpc = ip; w.stall = s; w.ecall = e; w.br = b;
    w.tgt = t; w.e_pc = xpc; w.e_hold = xh; w.e_flush = xf; w.e_bub = xb;
    w.e_we = xw; w.e_mepc = xm; w.e_busy = xy;
    vecs.push_back(w);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_pc = '0; stall_flag = 1'b0; ecall_flag = 1'b0;
    br_taken = 1'b0; br_target = '0;
  endtask

  initial begin
    int lat_we, lat_pc, n_we;

    rst_n = 1'b0;
    mtvec = 32'h0000_0103;
    idle_inputs();

    //  rst vld id_pc        stl ecl br  target        pc            hld fl  bub we  mepc          busy
    add(0, 0, 32'h0,     0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,  0); // 0 in reset
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,  0); // 1 BOOT
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,  0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h4,        0, 0, 0, 0, 32'h0,  0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h8,        0, 0, 0, 0, 32'h0,  0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'hC,        0, 0, 0, 0, 32'h0,  0);
    add(1, 1, 32'h0,     1, 0, 0, 32'h0,        32'h10,       1, 0, 1, 0, 32'h0,  0); // 6 stall
    add(1, 1, 32'h0,     1, 0, 0, 32'h0,        32'h10,       1, 0, 1, 0, 32'h0,  0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h10,       0, 0, 0, 0, 32'h0,  0);
    add(1, 1, 32'h0,     0, 1, 1, 32'h80,       32'h14,       0, 1, 1, 0, 32'h0,  0); // 9 br beats ecall
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h80,       0, 0, 0, 0, 32'h0,  0);
    add(1, 0, 32'h0,     1, 1, 0, 32'h0,        32'h84,       0, 0, 0, 0, 32'h0,  0); // 11 no id_valid
    add(1, 1, 32'h24,    0, 1, 0, 32'h0,        32'h88,       1, 0, 1, 0, 32'h0,  0); // 12 ecall
    add(1, 0, 32'h0,     0, 0, 1, 32'h200,      32'h88,       1, 0, 1, 0, 32'h24, 1); // DRAIN, br ignored
    add(1, 1, 32'h0,     1, 1, 0, 32'h0,        32'h88,       1, 0, 1, 0, 32'h24, 1);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h88,       1, 0, 1, 0, 32'h24, 1);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h88,       1, 0, 1, 1, 32'h24, 1); // 16 TRAP
    add(1, 0, 32'h0,     0, 0, 1, 32'h300,      32'h88,       0, 1, 1, 0, 32'h24, 1); // 17 REDIRECT
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h100,      0, 0, 0, 0, 32'h24, 0);
    add(1, 0, 32'h0,     0, 0, 1, 32'hFFFF_FFFC, 32'h104,     0, 1, 1, 0, 32'h24, 0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'hFFFF_FFFC, 0, 0, 0, 0, 32'h24, 0); // 20 wrap
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h24, 0);
    add(1, 1, 32'h40,    0, 1, 0, 32'h0,        32'h4,        1, 0, 1, 0, 32'h24, 0); // 22 ecall
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h4,        1, 0, 1, 0, 32'h40, 1);
    add(0, 0, 32'h0,     0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,  0); // 24 reset in DRAIN
    add(0, 0, 32'h0,     0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,  0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,  0); // BOOT again
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,  0);
    add(1, 0, 32'h0,     0, 0, 0, 32'h0,        32'h4,        0, 0, 0, 0, 32'h0,  0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; id_valid = vecs[i].valid; id_pc = vecs[i].idpc;
      stall_flag = vecs[i].stall; ecall_flag = vecs[i].ecall;
      br_taken = vecs[i].br; br_target = vecs[i].tgt;
      #1;
      chk("pc",           i, pc,                  vecs[i].e_pc);
      chk("if_id_hold",   i, 32'(if_id_hold),     32'(vecs[i].e_hold));
      chk("if_id_flush",  i, 32'(if_id_flush),    32'(vecs[i].e_flush));
      chk("id_ex_bubble", i, 32'(id_ex_bubble),   32'(vecs[i].e_bub));
      chk("mepc_we",      i, 32'(mepc_we),        32'(vecs[i].e_we));
      chk("mepc_data",    i, mepc_data,           vecs[i].e_mepc);
      chk("trap_busy",    i, 32'(trap_busy),      32'(vecs[i].e_busy));
      chk("mcause_data",  i, mcause_data,         32'd11);
      @(posedge clk); #1;
    end

    // ECALL latency: pc is 0x8 here; count cycles to the CSR strobe and to the mtvec fetch
    lat_we = -1; lat_pc = -1; n_we = 0;
    id_valid = 1'b1; ecall_flag = 1'b1; id_pc = 32'h0000_0008;
    #1;
    chk("pre_ecall_pc", 100, pc, 32'h8);
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 1; k <= 12; k++) begin
      #1;
      chk("hold_flush_excl", 100 + k, 32'(if_id_hold & if_id_flush), 32'd0);
      if (mepc_we) begin
        n_we++;
        if (lat_we < 0) lat_we = k;
        chk("lat_mepc_data", 100 + k, mepc_data, 32'h8);
      end
      if (pc == 32'h100 && lat_pc < 0) lat_pc = k;
      @(posedge clk); #1;
    end
    chk("lat_mepc_we",  200, 32'(lat_we), 32'd4);
    chk("lat_mtvec_pc", 201, 32'(lat_pc), 32'd6);
    chk("mepc_we_count", 202, 32'(n_we),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter DRAIN_CYCLES, default 3: number of drain cycles before a trap commits; legal range 1..7.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port id_valid, input, 1: the ID stage holds a valid instruction.
REQ-006 Port id_pc, input, 32: PC of the instruction in ID.
REQ-007 Port stall_flag, input, 1: load-use hazard from the decoder.
REQ-008 Port ecall_flag, input, 1: the ID instruction is ECALL.
REQ-009 Port br_taken, input, 1: the EX stage resolved a taken branch/jump this cycle.
REQ-010 Port br_target, input, 32: redirect address, valid when br_taken=1.
REQ-011 Port mtvec, input, 32: trap vector base.
REQ-012 Port pc, output, 32: registered fetch PC.
REQ-013 Port if_id_hold, output, 1: hold the IF/ID register.
REQ-014 Port if_id_flush, output, 1: load a bubble into IF/ID.
REQ-015 Port id_ex_bubble, output, 1: load a bubble into ID/EX.
REQ-016 Port mepc_we, output, 1: one-cycle CSR write strobe.
REQ-017 Port mepc_data, output, 32: trapping PC (registered).
REQ-018 Port mcause_data, output, 32: constant 32'd11 (environment call from M-mode).
REQ-019 Port trap_busy, output, 1: high in DRAIN, TRAP and REDIRECT.

Function
REQ-020 The FSM SHALL have the states BOOT, RUN, DRAIN, TRAP and REDIRECT, with BOOT entered on reset.
REQ-021 BOOT: if_id_flush=1, pc held; next state RUN after one cycle.
REQ-022 RUN priority: br_taken > (ecall_flag & id_valid) > (stall_flag & id_valid) > normal.
REQ-023 RUN+br_taken: pc <= br_target; if_id_flush=1 and id_ex_bubble=1 in the same cycle (combinational); no state change.
REQ-024 RUN+ecall: mepc register <= id_pc; if_id_hold=1, id_ex_bubble=1, pc held; counter <= DRAIN_CYCLES-1; state -> DRAIN.
REQ-025 RUN+stall: pc held, if_id_hold=1, id_ex_bubble=1; asserted every cycle stall_flag persists, with no added latency.
REQ-026 RUN normal: pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); all control outputs 0.
REQ-027 DRAIN: if_id_hold=1, id_ex_bubble=1, pc held; counter decrements each cycle; on counter==0 the state goes to TRAP.
REQ-028 TRAP: mepc_we=1 for exactly one cycle with mepc_data = latched PC; if_id_hold=1, id_ex_bubble=1; state -> REDIRECT.
REQ-029 REDIRECT: pc <= {mtvec[31:2], 2'b00}; if_id_flush=1, id_ex_bubble=1; state -> RUN.
REQ-030 br_taken, stall_flag and ecall_flag SHALL be ignored in DRAIN, TRAP and REDIRECT.
REQ-031 Ecall latency: mepc_we rises DRAIN_CYCLES+1 cycles after the ecall cycle, and the first fetch at mtvec occurs DRAIN_CYCLES+3 cycles after it.
REQ-032 if_id_hold and if_id_flush SHALL never be asserted together.

Reset
REQ-033 While rst_n=0: pc=RESET_PC, state=BOOT, counter=0, mepc register=0, mepc_we=0, trap_busy=0.
REQ-034 Reset asserted mid-trap SHALL abort the trap immediately with no mepc_we pulse, and operation SHALL restart from BOOT.

Verification
REQ-035 Release reset, idle inputs -> one cycle with if_id_flush=1, then pc sequence 0, 4, 8, ...
REQ-036 stall_flag=1 for 2 cycles at pc=0x10 -> pc stays 0x10 for 2 cycles, if_id_hold=1 and id_ex_bubble=1 in each, then pc=0x14.
REQ-037 br_taken=1 and ecall_flag=1 in the same cycle, br_target=0x80 -> pc=0x80, flush asserted, no trap_busy.
REQ-038 ecall at id_pc=0x24, mtvec=0x103 -> 3 busy DRAIN cycles, mepc_we pulse with mepc_data=0x24 and mcause_data=11, then pc=0x100.
REQ-039 pc=0xFFFF_FFFC, no events -> next pc=0x0000_0000.
REQ-040 rst_n low during DRAIN -> no mepc_we pulse, pc=RESET_PC, BOOT sequence repeats.
